// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes and holds the decode stage until every
// register the decode instruction reads is free of pending writes.
module hazard_scoreboard #(
    parameter int unsigned DEPTH     = 3,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [30:0] rmask,
    input  logic [30:0] wmask,
    input  logic        flush,
    output logic        stall,
    output logic        issue,
    output logic [30:0] busy,
    output logic [31:0] stall_count
);

    // With the write-back bypass the oldest slot has already written the
    // register file by the time decode reads it, so it never blocks.
    localparam int unsigned NBLOCK = WB_BYPASS ? DEPTH - 1 : DEPTH;

    logic [30:0] slot_q [DEPTH];
    logic [31:0] stall_count_q;

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < NBLOCK) begin
                busy = busy | slot_q[i];
            end
        end
    end

    always_comb begin
        stall = valid_in & ~flush & (|(rmask & busy));
        issue = valid_in & ~flush & ~stall;
    end

    // The pipe shifts every cycle; a non-issuing cycle inserts an empty slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            slot_q[0] <= issue ? wmask : '0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                slot_q[i] <= slot_q[i-1];
            end
            if (stall) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: each driven cycle pushes its expected outputs; a monitor
// on the falling edge pops and compares against two configurations.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [30:0] rmask = '0;
    logic [30:0] wmask = '0;
    logic        flush = 1'b0;

    logic        stall1, issue1, stall0, issue0;
    logic [30:0] busy1, busy0;
    logic [31:0] cnt1, cnt0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        s1;
        logic        i1;
        logic [30:0] b1;
        logic [31:0] c1;
        bit          chk0;
        logic        s0;
        logic        i0;
        logic [30:0] b0;
        logic [31:0] c0;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .rmask(rmask), .wmask(wmask),
        .flush(flush), .stall(stall1), .issue(issue1), .busy(busy1), .stall_count(cnt1)
    );

    hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1'b0)) dut0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .rmask(rmask), .wmask(wmask),
        .flush(flush), .stall(stall0), .issue(issue0), .busy(busy0), .stall_count(cnt0)
    );

    task automatic check(input string name, input string field, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, "byp_stall", {31'd0, stall1}, {31'd0, e.s1});
            check(e.name, "byp_issue", {31'd0, issue1}, {31'd0, e.i1});
            check(e.name, "byp_busy", {1'b0, busy1}, {1'b0, e.b1});
            check(e.name, "byp_count", cnt1, e.c1);
            if (e.chk0) begin
                check(e.name, "nobyp_stall", {31'd0, stall0}, {31'd0, e.s0});
                check(e.name, "nobyp_issue", {31'd0, issue0}, {31'd0, e.i0});
                check(e.name, "nobyp_busy", {1'b0, busy0}, {1'b0, e.b0});
                check(e.name, "nobyp_count", cnt0, e.c0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        valid_in = 1'b0;
        rmask = '0;
        wmask = '0;
        flush = 1'b0;
    endtask

    task automatic step(input string name, input logic v, input logic [30:0] r,
                        input logic [30:0] w, input logic f, input logic rst,
                        input logic s1, input logic i1, input logic [30:0] b1,
                        input logic [31:0] c1, input bit chk0, input logic s0,
                        input logic i0, input logic [30:0] b0, input logic [31:0] c0);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        valid_in = v;
        rmask = r;
        wmask = w;
        flush = f;
        e.name = name;
        e.s1 = s1; e.i1 = i1; e.b1 = b1; e.c1 = c1;
        e.chk0 = chk0;
        e.s0 = s0; e.i0 = i0; e.b0 = b0; e.c0 = c0;
        exp_q.push_back(e);
    endtask

    localparam logic [30:0] T0  = 31'h80;
    localparam logic [30:0] T1  = 31'h100;
    localparam logic [30:0] RA  = 31'h4000_0000;

    initial begin
        // Reset state, then a reader that also writes what it reads
        do_reset();
        step("rst_first", 1, T0, '0, 0, 0, 0, 1, '0, 0, 1, 0, 1, '0, 0);
        step("self_rw",   1, T0, T0, 0, 0, 0, 1, '0, 0, 1, 0, 1, '0, 0);
        step("self_next", 1, T0, '0, 0, 0, 1, 0, T0, 0, 1, 1, 0, T0, 0);

        // RAW window, both bypass settings
        do_reset();
        step("raw_prod", 1, '0, T0, 0, 0, 0, 1, '0, 0, 1, 0, 1, '0, 0);
        step("raw_c1",   1, T0, '0, 0, 0, 1, 0, T0, 0, 1, 1, 0, T0, 0);
        step("raw_c2",   1, T0, '0, 0, 0, 1, 0, T0, 1, 1, 1, 0, T0, 1);
        step("raw_c3",   1, T0, '0, 0, 0, 0, 1, '0, 2, 1, 1, 0, T0, 2);
        step("raw_c4",   1, T0, '0, 0, 0, 0, 1, '0, 2, 1, 0, 1, '0, 3);

        // Independent reader issues immediately
        do_reset();
        step("ind_prod", 1, '0, T0, 0, 0, 0, 1, '0, 0, 1, 0, 1, '0, 0);
        step("ind_rd",   1, T1, '0, 0, 0, 0, 1, T0, 0, 1, 0, 1, T0, 0);

        // Link register hazard
        do_reset();
        step("jal_prod", 1, '0, RA, 0, 0, 0, 1, '0, 0, 0, 0, 0, '0, 0);
        step("jal_c1",   1, RA, '0, 0, 0, 1, 0, RA, 0, 0, 0, 0, '0, 0);
        step("jal_c2",   1, RA, '0, 0, 0, 1, 0, RA, 1, 0, 0, 0, '0, 0);
        step("jal_c3",   1, RA, '0, 0, 0, 0, 1, '0, 2, 0, 0, 0, '0, 0);

        // Flush beats stall; the flushed wmask must not enter the pipe
        do_reset();
        step("fl_prod", 1, '0, T0, 0, 0, 0, 1, '0, 0, 0, 0, 0, '0, 0);
        step("fl_c1",   1, T0, '0, 0, 0, 1, 0, T0, 0, 0, 0, 0, '0, 0);
        step("fl_c2",   1, T0, 31'h200, 1, 0, 0, 0, T0, 1, 0, 0, 0, '0, 0);
        step("fl_c3",   1, 31'h280, '0, 0, 0, 0, 1, '0, 1, 0, 0, 0, '0, 0);

        // Idle decode inserts a bubble and holds the counter
        do_reset();
        step("idle_prod", 1, '0, T0, 0, 0, 0, 1, '0, 0, 0, 0, 0, '0, 0);
        step("idle_c1",   0, T0, '0, 0, 0, 0, 0, T0, 0, 0, 0, 0, '0, 0);
        step("idle_c2",   1, T0, '0, 0, 0, 1, 0, T0, 0, 0, 0, 0, '0, 0);
        step("idle_c3",   1, T0, '0, 0, 0, 0, 1, '0, 1, 0, 0, 0, '0, 0);

        // Reset while stalled discards pending writes and the count
        do_reset();
        step("rs_prod", 1, '0, T0, 0, 0, 0, 1, '0, 0, 1, 0, 1, '0, 0);
        step("rs_c1",   1, T0, '0, 0, 0, 1, 0, T0, 0, 1, 1, 0, T0, 0);
        step("rs_c2",   1, T0, '0, 0, 1, 1, 0, T0, 1, 1, 1, 0, T0, 1);
        step("rs_c3",   1, T0, '0, 0, 0, 0, 1, '0, 0, 1, 0, 1, '0, 0);

        // Counter wrap from all-ones
        do_reset();
        step("wr_prod", 1, '0, T0, 0, 0, 0, 1, '0, 0, 0, 0, 0, '0, 0);
        step("wr_c1",   1, T0, '0, 0, 0, 1, 0, T0, 32'hFFFF_FFFF, 0, 0, 0, '0, 0);
        #1;
        force dut.stall_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_count_q;
        step("wr_c2",   1, T0, '0, 0, 0, 1, 0, T0, 0, 0, 0, 0, '0, 0);

        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending entries", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Tracks register writes still in flight in the in-order pipeline and decides, each cycle, whether the instruction in decode may issue. Consumes the 31-bit read/write register masks produced alongside decode: bit i-1 stands for GPR i, bit 30 is $ra, and $zero has no bit. Issues an instruction when no in-flight write targets any register it reads; otherwise holds decode and injects a bubble. Sits between decode and the ID/EX register, and drives the decode-stage stall and the bubble-insert control.

## Interface
- DEPTH, 3, number of tracked in-flight slots (EX, MEM, WB); legal range 2..8
- WB_BYPASS, 1, when 1 the oldest slot does not block (register file writes in the first half-cycle and reads in the second); when 0 every slot blocks
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is sampled high
- valid_in  input  1  decode holds a real instruction this cycle
- rmask  input  31  registers read by the decode instruction
- wmask  input  31  registers written by the decode instruction
- flush  input  1  kill the decode instruction this cycle (taken branch or jump redirect)
- stall  output  1  combinational; hold PC and IF/ID this cycle
- issue  output  1  combinational; decode instruction enters EX at the next edge
- busy  output  31  combinational; OR of the blocking slots
- stall_count  output  32  registered; number of cycles with stall=1 since reset

## Operation
- State: slot[0..DEPTH-1], each 31 bits; slot[0] is youngest (EX), slot[DEPTH-1] is oldest (WB).
- busy = OR of slot[0..DEPTH-2] when WB_BYPASS=1; OR of slot[0..DEPTH-1] when WB_BYPASS=0.
- stall = valid_in & ~flush & |(rmask & busy).
- issue = valid_in & ~flush & ~stall.
- WAW is not checked. Writes retire in order, so a younger write always lands last.
- Shift on every edge, whether or not decode stalls: slot[i] <= slot[i-1] for i>=1; slot[0] <= issue ? wmask : 0. A stall therefore inserts an all-zero bubble slot.
- stall_count <= stall_count + 1 when stall=1. It wraps modulo 2^32 from 0xFFFFFFFF to 0.
- flush takes priority over stall. A flushed instruction neither stalls nor issues, slot[0] loads 0, and stall_count does not increment.
- The masks are used as given. The block does not decode opcodes and does not add a $zero bit.

## Timing
- Reset: every slot, busy, and stall_count read 0 on the cycle after reset is sampled. stall and issue are then driven only by valid_in and flush, so any valid, unflushed instruction issues.
- Reset during a stall: every pending write is discarded, and the held instruction issues on the next cycle.
- stall and issue depend combinationally on valid_in, flush, rmask and slot state, with no added latency. wmask affects only the state at the next edge.
- RAW distance: a producer issued at cycle t blocks a reader for cycles t+1 .. t+DEPTH-1 when WB_BYPASS=1, and t+1 .. t+DEPTH when WB_BYPASS=0.
  - At DEPTH=3 with WB_BYPASS=1, that is a 2-stall window for an adjacent reader.
- An instruction that both reads and writes the same register is checked only against older writes, never against its own wmask.
- valid_in=0: stall=0, issue=0, a bubble shifts in, and the counter holds.

## Test plan
- Reset, then valid_in=1, rmask=0x80, wmask=0 -> issue=1 and stall=0 on the first cycle; busy=0; stall_count=0.
- DEPTH=3, WB_BYPASS=1: cycle 0 issue with wmask=0x80 ($t0), then hold rmask=0x80 from cycle 1 -> stall=1 in cycles 1 and 2, issue=1 in cycle 3, stall_count=2.
- Same sequence with WB_BYPASS=0 -> stall in cycles 1, 2 and 3, issue in cycle 4, stall_count=3. A reader with rmask=0x100 ($t1) issues immediately in both configurations.
- JAL with wmask=0x40000000, then a reader with rmask=0x40000000 -> 2 stall cycles (DEPTH=3, WB_BYPASS=1); busy[30]=1 during the stall.
- Stalled reader with flush asserted in cycle 2 -> stall=0 and issue=0 in that cycle; slot[0] loads 0; stall_count increments only for cycle 1.
- Producer issued, reset asserted in cycle 1 while the reader is stalled -> from cycle 2, busy=0, stall_count=0, and the reader issues. Separately, preload stall_count to 0xFFFFFFFF by running the counter and force one stall -> count wraps to 0.
